// File: rtl/ucr_seq_ctl.sv
// ucr_seq_ctl: command sequencer for a cascade of 4-bit universal up/down
// counter slices. Drives the chain's SEL, D and CIN so that SEL never moves
// while CIN is high and every CIN pulse is preceded and followed by a low cycle.
// Optional feature: define UCR_SEQ_ABORT_EN to add the ABORT input.
module ucr_seq_ctl #(
    parameter int SLICES = 3,
    localparam int W = 4 * SLICES
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         CMD_VALID,
    output logic         CMD_READY,
    input  logic [1:0]   CMD_OP,
    input  logic [W-1:0] CMD_DATA,
    output logic [1:0]   CTR_SEL,
    output logic [W-1:0] CTR_D,
    output logic         CTR_CIN,
    input  logic [W-1:0] CTR_Q,
`ifdef UCR_SEQ_ABORT_EN
    input  logic         ABORT,
`endif
    input  logic         CTR_COUT,
    output logic         DONE,
    output logic         HIT_TERM,
    output logic [W-1:0] STEPS
);

    localparam logic [1:0] SEL_LOAD = 2'b00;
    localparam logic [1:0] SEL_DEC  = 2'b01;
    localparam logic [1:0] SEL_INC  = 2'b10;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_DZ   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SETUP = 3'd2,
        S_PULSE = 3'd3,
        S_CHECK = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   sel_q, sel_d;
    logic [W-1:0] d_q, d_d;
    logic         cin_q, cin_d;
    logic         done_q, done_d;
    logic         hit_q, hit_d;
    logic [W-1:0] steps_q, steps_d;
    logic [W-1:0] rem_q, rem_d;
    logic         bounded_q, bounded_d;
    logic         abort_hit_s;

    // The chain value is only observed by the host; the sequencer decides on COUT alone.
    logic         q_seen_s;
    assign q_seen_s = ^CTR_Q;

`ifdef UCR_SEQ_ABORT_EN
    logic abort_q, abort_d;
    // Abort request is live now or was seen while a pulse was in its high phase.
    always_comb abort_hit_s = ABORT | abort_q;
`else
    assign abort_hit_s = 1'b0;
`endif

    assign CMD_READY = (state_q == S_IDLE);
    assign CTR_SEL   = sel_q;
    assign CTR_D     = d_q;
    assign CTR_CIN   = cin_q;
    assign DONE      = done_q;
    assign HIT_TERM  = hit_q;
    assign STEPS     = steps_q;

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        d_d       = d_q;
        cin_d     = cin_q;
        done_d    = 1'b0;
        hit_d     = hit_q;
        steps_d   = steps_q;
        rem_d     = rem_q;
        bounded_d = bounded_q;
`ifdef UCR_SEQ_ABORT_EN
        abort_d   = abort_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (CMD_VALID) begin
                    hit_d   = 1'b0;
                    steps_d = {W{1'b0}};
                    cin_d   = 1'b0;
`ifdef UCR_SEQ_ABORT_EN
                    abort_d = 1'b0;
`endif
                    if (CMD_OP == OP_LOAD) begin
                        d_d     = CMD_DATA;
                        sel_d   = SEL_LOAD;
                        state_d = S_LOAD;
                    end else begin
                        sel_d     = (CMD_OP == OP_INC) ? SEL_INC : SEL_DEC;
                        rem_d     = CMD_DATA;
                        bounded_d = (CMD_OP != OP_DZ);
                        state_d   = S_SETUP;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                // The chain has taken D on this edge; park it in HOLD.
                sel_d   = SEL_HOLD;
                state_d = S_FIN;
            end
            S_SETUP, S_CHECK: begin
                // CIN is low and SEL has been stable for a full cycle here,
                // so COUT reflects the settled chain value.
                if (abort_hit_s) begin
                    sel_d   = SEL_HOLD;
                    hit_d   = 1'b0;
                    state_d = S_FIN;
                end else if (CTR_COUT) begin
                    sel_d   = SEL_HOLD;
                    hit_d   = 1'b1;
                    state_d = S_FIN;
                end else if (bounded_q && (rem_q == {W{1'b0}})) begin
                    sel_d   = SEL_HOLD;
                    hit_d   = 1'b0;
                    state_d = S_FIN;
                end else begin
                    cin_d   = 1'b1;
                    rem_d   = rem_q - {{(W-1){1'b0}}, 1'b1};
                    steps_d = steps_q + {{(W-1){1'b0}}, 1'b1};
                    state_d = S_PULSE;
                end
            end
            S_PULSE: begin
                // Always complete the low phase before any SEL change.
                cin_d   = 1'b0;
                state_d = S_CHECK;
`ifdef UCR_SEQ_ABORT_EN
                if (ABORT) begin
                    abort_d = 1'b1;
                end else begin
                    abort_d = abort_q;
                end
`endif
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                sel_d   = SEL_HOLD;
                cin_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer registers with synchronous reset; reset abandons any command.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            sel_q     <= SEL_HOLD;
            d_q       <= {W{1'b0}};
            cin_q     <= 1'b0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
            steps_q   <= {W{1'b0}};
            rem_q     <= {W{1'b0}};
            bounded_q <= 1'b0;
`ifdef UCR_SEQ_ABORT_EN
            abort_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            d_q       <= d_d;
            cin_q     <= cin_d;
            done_q    <= done_d;
            hit_q     <= hit_d;
            steps_q   <= steps_d;
            rem_q     <= rem_d;
            bounded_q <= bounded_d;
`ifdef UCR_SEQ_ABORT_EN
            abort_q   <= abort_d;
`endif
        end
    end

endmodule

// File: tb/tb_ucr_seq_ctl.sv
// Self-checking bench for ucr_seq_ctl with a behavioural counter-chain model.
module tb_ucr_seq_ctl;

    localparam int SLICES = 3;
    localparam int W = 4 * SLICES;

    localparam logic [1:0] OP_LD = 2'b00;
    localparam logic [1:0] OP_DN = 2'b01;
    localparam logic [1:0] OP_IN = 2'b10;
    localparam logic [1:0] OP_DZ = 2'b11;

    logic         CLK;
    logic         RESET;
    logic         CMD_VALID;
    logic         CMD_READY;
    logic [1:0]   CMD_OP;
    logic [W-1:0] CMD_DATA;
    logic [1:0]   CTR_SEL;
    logic [W-1:0] CTR_D;
    logic         CTR_CIN;
    logic [W-1:0] CTR_Q;
    logic         CTR_COUT;
    logic         DONE;
    logic         HIT_TERM;
    logic [W-1:0] STEPS;
    logic         ABORT;

    ucr_seq_ctl #(.SLICES(SLICES)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .CMD_VALID(CMD_VALID),
        .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP),
        .CMD_DATA(CMD_DATA),
        .CTR_SEL(CTR_SEL),
        .CTR_D(CTR_D),
        .CTR_CIN(CTR_CIN),
        .CTR_Q(CTR_Q),
`ifdef UCR_SEQ_ABORT_EN
        .ABORT(ABORT),
`endif
        .CTR_COUT(CTR_COUT),
        .DONE(DONE),
        .HIT_TERM(HIT_TERM),
        .STEPS(STEPS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Counter chain model: loads on CLK in LOAD mode, counts once per CIN pulse.
    logic [W-1:0] chain_q = '0;
    always @(posedge CLK) begin
        if (CTR_SEL == 2'b00) chain_q <= CTR_D;
        else if (CTR_CIN === 1'b1 && CTR_SEL == 2'b01) chain_q <= chain_q - 1'b1;
        else if (CTR_CIN === 1'b1 && CTR_SEL == 2'b10) chain_q <= chain_q + 1'b1;
    end
    assign CTR_Q    = chain_q;
    assign CTR_COUT = ((CTR_SEL == 2'b01) && (chain_q == '0)) ||
                      ((CTR_SEL == 2'b10) && (&chain_q));

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    int pulse_base = 0;
    logic rst_seen = 1'b1;
    logic [1:0] prev_sel = 2'b11;
    logic prev_cin = 1'b0;

    function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Pulse counter and reset-edge tracker.
    always @(posedge CLK) begin
        if (CTR_CIN === 1'b1) pulse_cnt <= pulse_cnt + 1;
        rst_seen <= RESET;
    end

    // SEL/CIN safety invariants, skipped on the cycle after a reset edge.
    always @(negedge CLK) begin
        if (rst_seen === 1'b0) begin
            if (CTR_SEL !== prev_sel)
                chk("sel_change_cin_low", W'({prev_cin, CTR_CIN}), W'(0));
            if (CTR_CIN === 1'b1) begin
                chk("cin_sel_stable", W'(((CTR_SEL == 2'b01) || (CTR_SEL == 2'b10)) && (CTR_SEL == prev_sel)), W'(1));
                chk("cin_not_double", W'(prev_cin), W'(0));
            end
        end
        prev_sel <= CTR_SEL;
        prev_cin <= CTR_CIN;
    end

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] data;
        logic         chk_steps;
        logic [W-1:0] steps;
        logic         hit;
        logic [W-1:0] q;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[17];

    function automatic vec_t mk(input logic [1:0] op, input logic [W-1:0] data,
                                input logic [W-1:0] steps, input logic hit, input logic [W-1:0] q);
        vec_t v;
        v.op = op; v.data = data; v.chk_steps = (op != OP_LD);
        v.steps = steps; v.hit = hit; v.q = q;
        return v;
    endfunction

    task automatic issue(input vec_t v);
        int k;
        k = 0;
        @(negedge CLK);
        while (CMD_READY !== 1'b1 && k < 300) begin
            @(negedge CLK);
            k++;
        end
        chk("ready_before_issue", W'(CMD_READY), W'(1));
        pulse_base = pulse_cnt;
        CMD_VALID = 1'b1; CMD_OP = v.op; CMD_DATA = v.data;
        sb.push_back(v);
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
    endtask

    task automatic finish_cmd();
        bit got;
        vec_t e;
        got = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                got = 1;
                break;
            end
        end
        if (!got || sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_wait: no DONE within 300 cycles (queued %0d)", sb.size());
        end else begin
            e = sb.pop_front();
            if (e.chk_steps) chk("steps", STEPS, e.steps);
            chk("hit_term", W'(HIT_TERM), W'(e.hit));
            chk("chain_q", chain_q, e.q);
            chk("pulses", W'(pulse_cnt - pulse_base), e.steps);
            chk("sel_hold_at_done", W'(CTR_SEL), W'(2'b11));
            chk("ready_at_done", W'(CMD_READY), W'(1));
        end
    endtask

    task automatic run_cmd(input vec_t v);
        issue(v);
        finish_cmd();
    endtask

    initial begin
        tbl[0]  = mk(OP_LD, 12'hA5C, 12'd0,  1'b0, 12'hA5C);
        tbl[1]  = mk(OP_LD, 12'h005, 12'd0,  1'b0, 12'h005);
        tbl[2]  = mk(OP_DN, 12'd3,   12'd3,  1'b0, 12'h002);
        tbl[3]  = mk(OP_DN, 12'd10,  12'd2,  1'b1, 12'h000);
        tbl[4]  = mk(OP_LD, 12'hFFD, 12'd0,  1'b0, 12'hFFD);
        tbl[5]  = mk(OP_IN, 12'd0,   12'd0,  1'b0, 12'hFFD);
        tbl[6]  = mk(OP_IN, 12'd5,   12'd2,  1'b1, 12'hFFF);
        tbl[7]  = mk(OP_LD, 12'h010, 12'd0,  1'b0, 12'h010);
        tbl[8]  = mk(OP_DZ, 12'hABC, 12'd16, 1'b1, 12'h000);
        tbl[9]  = mk(OP_LD, 12'h000, 12'd0,  1'b0, 12'h000);
        tbl[10] = mk(OP_DZ, 12'd5,   12'd0,  1'b1, 12'h000);
        tbl[11] = mk(OP_LD, 12'hFFE, 12'd0,  1'b0, 12'hFFE);
        tbl[12] = mk(OP_IN, 12'd1,   12'd1,  1'b1, 12'hFFF);
        tbl[13] = mk(OP_LD, 12'h7FF, 12'd0,  1'b0, 12'h7FF);
        tbl[14] = mk(OP_IN, 12'd1,   12'd1,  1'b0, 12'h800);
        tbl[15] = mk(OP_LD, 12'h003, 12'd0,  1'b0, 12'h003);
        tbl[16] = mk(OP_DZ, 12'hFFF, 12'd3,  1'b1, 12'h000);

        RESET = 1'b1; CMD_VALID = 1'b0; CMD_OP = 2'b00; CMD_DATA = '0; ABORT = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_sel", W'(CTR_SEL), W'(2'b11));
        chk("rst_cin", W'(CTR_CIN), W'(0));
        chk("rst_d", CTR_D, W'(0));
        chk("rst_done", W'(DONE), W'(0));
        chk("rst_hit", W'(HIT_TERM), W'(0));
        chk("rst_steps", STEPS, W'(0));
        chk("rst_ready", W'(CMD_READY), W'(1));
        RESET = 1'b0;

        // LOAD timing: SEL=00 for one cycle, DONE two cycles after accept.
        @(negedge CLK);
        CMD_VALID = 1'b1; CMD_OP = OP_LD; CMD_DATA = 12'hA5C;
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
        @(negedge CLK);
        chk("ld_sel_load", W'(CTR_SEL), W'(2'b00));
        chk("ld_d", CTR_D, 12'hA5C);
        chk("ld_busy", W'(CMD_READY), W'(0));
        chk("ld_no_done_t1", W'(DONE), W'(0));
        @(negedge CLK);
        chk("ld_sel_hold", W'(CTR_SEL), W'(2'b11));
        chk("ld_no_done_t2", W'(DONE), W'(0));
        @(negedge CLK);
        chk("ld_done", W'(DONE), W'(1));
        chk("ld_hit", W'(HIT_TERM), W'(0));
        chk("ld_q", chain_q, 12'hA5C);
        @(negedge CLK);
        chk("ld_done_pulse", W'(DONE), W'(0));

        // Table-driven commands.
        for (int i = 0; i < 17; i++) run_cmd(tbl[i]);

        // Busy commands are ignored and do not disturb the running one.
        run_cmd(mk(OP_LD, 12'h005, 12'd0, 1'b0, 12'h005));
        issue(mk(OP_DN, 12'd3, 12'd3, 1'b0, 12'h002));
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            CMD_VALID = 1'b1; CMD_OP = OP_LD; CMD_DATA = 12'h000;
            chk("busy_not_ready", W'(CMD_READY), W'(0));
        end
        @(negedge CLK);
        CMD_VALID = 1'b0;
        finish_cmd();

`ifdef UCR_SEQ_ABORT_EN
        // Abort during the third pulse.
        run_cmd(mk(OP_LD, 12'h100, 12'd0, 1'b0, 12'h100));
        issue(mk(OP_DN, 12'd8, 12'd3, 1'b0, 12'h0FD));
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (CTR_CIN === 1'b1 && (pulse_cnt - pulse_base) == 2) break;
        end
        ABORT = 1'b1;
        @(posedge CLK);
        #1 ABORT = 1'b0;
        finish_cmd();
`endif

        // Reset during the fourth pulse of DEC_TO_ZERO.
        run_cmd(mk(OP_LD, 12'h010, 12'd0, 1'b0, 12'h010));
        issue(mk(OP_DZ, 12'd0, 12'd16, 1'b1, 12'h000));
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (CTR_CIN === 1'b1 && (pulse_cnt - pulse_base) == 3) break;
        end
        RESET = 1'b1;
        @(negedge CLK);
        chk("rst_mid_cin", W'(CTR_CIN), W'(0));
        chk("rst_mid_sel", W'(CTR_SEL), W'(2'b11));
        chk("rst_mid_done", W'(DONE), W'(0));
        RESET = 1'b0;
        sb.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("rst_mid_no_done", W'(DONE), W'(0));
        end
        chk("rst_mid_q", chain_q, 12'h00C);
        chk("rst_mid_pulses", W'(pulse_cnt - pulse_base), W'(4));
        chk("rst_mid_steps", STEPS, W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
